dispatch: RTL and testbench
===========================

DISPATCH -- requirements
Module: dispatch

Interface
REQ-001 Parameters (name, default, meaning):
- MAX_DEPENDENCIES, 256, dependency vector width
- NUM_EXECUTORS, 4, executor slots, power of two, 2..16
- SLOT_W, $clog2(NUM_EXECUTORS), slot index width
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge
- rst_n, in, 1, asynchronous active-low reset
- s_axis_tvalid, in, 1, batched transaction valid (from batch stage)
- s_axis_tready, out, 1, dispatch accepts
- s_axis_tdata_owner_programID, in, 64, transaction owner
- s_axis_tdata_read_dependencies, in, MAX_DEPENDENCIES, read set
- s_axis_tdata_write_dependencies, in, MAX_DEPENDENCIES, write set
- m_axis_tvalid, out, 1, issue to executor valid
- m_axis_tready, in, 1, executor fabric accepts
- m_axis_tdest, out, SLOT_W, target executor slot
- m_axis_tdata_owner_programID, out, 64, issued owner
- done_valid, in, 1, executor completion strobe
- done_slot, in, SLOT_W, completing slot
- inflight_count, out, 32, busy slots
- dispatched_count, out, 32, issue handshakes
- stall_cycles, out, 32, cycles with s_axis_tvalid=1, s_axis_tready=0
- spurious_done, out, 32, ignored completions

Function
REQ-003 Per slot SHALL hold: busy, issued flag, programID, read set, write set.
REQ-004 Lock vectors SHALL be OR of read sets (lock_r) and write sets (lock_w) over busy slots, from registered state.
REQ-005 hazard SHALL be ((in_r|in_w)&lock_w)!=0 or (in_w&lock_r)!=0 (RAW, WAW, WAR vs in-flight).
REQ-006 FSM states IDLE, ISSUE; reset to IDLE.
REQ-007 s_axis_tready SHALL be 1 only in IDLE with a non-busy slot and hazard=0; SHALL not depend on s_axis_tvalid.
REQ-008 Accept (IDLE, tvalid&tready): lowest-index free slot SHALL be loaded, busy=1, issued=0; state to ISSUE next cycle.
REQ-009 In ISSUE, m_axis_tvalid SHALL be 1, tdest=loaded slot, programID=its owner, all stable until m_axis_tready; handshake sets issued=1, returns to IDLE, increments dispatched_count.
REQ-010 Accept-to-m_axis_tvalid latency SHALL be 1 cycle; max one accept per two cycles.
REQ-011 done_valid on slot with busy=1 and issued=1 SHALL clear busy next edge; otherwise (idle, or not yet issued) SHALL be ignored and spurious_done incremented.
REQ-012 Completion and accept same cycle: freed slot/locks SHALL become visible only next cycle (tready uses pre-edge state).
REQ-013 Completion of the slot in ISSUE during its handshake cycle SHALL be spurious (issued still 0 pre-edge).
REQ-014 All slots busy: tready=0; stall_cycles counts while tvalid=1.
REQ-015 inflight_count SHALL equal number of busy slots, updated each edge.
REQ-016 32-bit counters SHALL wrap at 2^32-1 to 0.

Reset
REQ-017 rst_n low SHALL asynchronously clear: state IDLE, all busy/issued 0, payloads 0, m_axis_tvalid 0, tdest 0, programID out 0, all counters 0, s_axis_tready 0 while asserted.
REQ-018 Reset mid-ISSUE SHALL drop the pending issue with no handshake; in-flight executor work is forgotten, later completions count spurious.
REQ-019 Release SHALL need no post-reset init cycle; tready may be 1 the first cycle after deassertion.

Structure
REQ-020 Shared package SHALL hold MAX_DEPENDENCIES default, FSM state enum, slot-record typedef.
REQ-021 Single sub-module dispatch_slot_alloc: busy vector in, lowest free index and any_free out, combinational.

Verification
REQ-022 Reset, m_axis_tready=1, send ID 0x11 w={bit3} -> tvalid next cycle, tdest=0, dispatched_count=1, inflight=1.
REQ-023 Slot0 busy w={bit3}; send r={bit3} -> tready=0, stall_cycles increments until done_slot=0, accept the following cycle.
REQ-024 Fill 4 disjoint transactions, m_axis_tready=1 -> tdest 0,1,2,3; 5th stalls; done_slot=2 -> 5th issues with tdest=2.
REQ-025 m_axis_tready=0 for 5 cycles -> tvalid, tdest, programID stable; tready=0; one handshake on release.
REQ-026 done_slot=1 with slot1 idle, and done on slot during its unhandshaken ISSUE -> spurious_done=2, busy unchanged.
REQ-027 rst_n low mid-ISSUE -> same cycle tvalid=0, inflight=0, counters 0; post-release accept uses slot 0.

Source files
------------

// File: rtl/dispatch_pkg.sv
// Shared types for the dispatch stage: dependency width default, FSM states and the
// per-slot bookkeeping record.
package dispatch_pkg;

    localparam int unsigned MAX_DEPENDENCIES_DEFAULT = 256;
    localparam int unsigned OWNER_W = 64;

    typedef enum logic [0:0] {
        StIdle,
        StIssue
    } state_e;

    // Dependency sets live in separate arrays so their width can follow MAX_DEPENDENCIES.
    typedef struct packed {
        logic               busy;
        logic               issued;
        logic [OWNER_W-1:0] owner;
    } slot_rec_t;

endpackage

// File: rtl/dispatch_if.sv
// Ingress stream, issue stream and completion strobe of the dispatch stage.
// slave is the dispatch view, master is the view of its surroundings.
interface dispatch_if
    import dispatch_pkg::*;
#(
    parameter int unsigned MAX_DEPENDENCIES = MAX_DEPENDENCIES_DEFAULT,
    parameter int unsigned SLOT_W           = 2
);

    logic                        s_axis_tvalid;
    logic                        s_axis_tready;
    logic [OWNER_W-1:0]          s_axis_tdata_owner_programID;
    logic [MAX_DEPENDENCIES-1:0] s_axis_tdata_read_dependencies;
    logic [MAX_DEPENDENCIES-1:0] s_axis_tdata_write_dependencies;
    logic                        m_axis_tvalid;
    logic                        m_axis_tready;
    logic [SLOT_W-1:0]           m_axis_tdest;
    logic [OWNER_W-1:0]          m_axis_tdata_owner_programID;
    logic                        done_valid;
    logic [SLOT_W-1:0]           done_slot;

    modport slave (
        input  s_axis_tvalid,
        output s_axis_tready,
        input  s_axis_tdata_owner_programID,
        input  s_axis_tdata_read_dependencies,
        input  s_axis_tdata_write_dependencies,
        output m_axis_tvalid,
        input  m_axis_tready,
        output m_axis_tdest,
        output m_axis_tdata_owner_programID,
        input  done_valid,
        input  done_slot
    );

    modport master (
        output s_axis_tvalid,
        input  s_axis_tready,
        output s_axis_tdata_owner_programID,
        output s_axis_tdata_read_dependencies,
        output s_axis_tdata_write_dependencies,
        input  m_axis_tvalid,
        output m_axis_tready,
        input  m_axis_tdest,
        input  m_axis_tdata_owner_programID,
        output done_valid,
        output done_slot
    );

endinterface

// File: rtl/dispatch_slot_alloc.sv
// Combinational lowest-index free-slot finder over the executor busy vector.
module dispatch_slot_alloc
    import dispatch_pkg::*;
#(
    parameter int unsigned NUM_EXECUTORS = 4,
    parameter int unsigned SLOT_W        = $clog2(NUM_EXECUTORS)
) (
    input  logic [NUM_EXECUTORS-1:0] busy,
    output logic [SLOT_W-1:0]        free_idx,
    output logic                     any_free
);

    // Scan downwards so the last hit written is the lowest free index.
    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        for (int i = NUM_EXECUTORS - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_idx = SLOT_W'(i);
                any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dispatch.sv
// Hazard-checked dispatch of batched transactions onto executor slots, one issue at a time,
// with completion tracking and activity counters.
module dispatch
    import dispatch_pkg::*;
#(
    parameter int unsigned MAX_DEPENDENCIES = MAX_DEPENDENCIES_DEFAULT,
    parameter int unsigned NUM_EXECUTORS    = 4,
    parameter int unsigned SLOT_W           = $clog2(NUM_EXECUTORS)
) (
    input  logic        clk,
    input  logic        rst_n,
    dispatch_if.slave   bus,
    output logic [31:0] inflight_count,
    output logic [31:0] dispatched_count,
    output logic [31:0] stall_cycles,
    output logic [31:0] spurious_done
);

    state_e                      state_q, state_d;
    slot_rec_t                   slot_q [NUM_EXECUTORS];
    logic [MAX_DEPENDENCIES-1:0] rd_q   [NUM_EXECUTORS];
    logic [MAX_DEPENDENCIES-1:0] wr_q   [NUM_EXECUTORS];
    logic [SLOT_W-1:0]           cur_q;

    logic [NUM_EXECUTORS-1:0]    busy_vec;
    logic [MAX_DEPENDENCIES-1:0] lock_r, lock_w;
    logic [SLOT_W-1:0]           free_idx;
    logic                        any_free;
    logic                        hazard, ready, accept, handshake, done_hit;

    always_comb begin
        busy_vec       = '0;
        lock_r         = '0;
        lock_w         = '0;
        inflight_count = '0;
        for (int i = 0; i < NUM_EXECUTORS; i++) begin
            busy_vec[i]    = slot_q[i].busy;
            inflight_count = inflight_count + 32'(slot_q[i].busy);
            if (slot_q[i].busy) begin
                lock_r = lock_r | rd_q[i];
                lock_w = lock_w | wr_q[i];
            end
        end
    end

    dispatch_slot_alloc #(
        .NUM_EXECUTORS(NUM_EXECUTORS),
        .SLOT_W       (SLOT_W)
    ) u_slot_alloc (
        .busy    (busy_vec),
        .free_idx(free_idx),
        .any_free(any_free)
    );

    assign hazard = (|((bus.s_axis_tdata_read_dependencies | bus.s_axis_tdata_write_dependencies)
                        & lock_w))
                  || (|(bus.s_axis_tdata_write_dependencies & lock_r));

    // rst_n gates ready so nothing is offered while reset is held.
    assign ready     = rst_n && (state_q == StIdle) && any_free && !hazard;
    assign accept    = bus.s_axis_tvalid && ready;
    assign handshake = (state_q == StIssue) && bus.m_axis_tready;
    assign done_hit  = slot_q[bus.done_slot].busy && slot_q[bus.done_slot].issued;

    assign bus.s_axis_tready                = ready;
    assign bus.m_axis_tvalid                = (state_q == StIssue);
    assign bus.m_axis_tdest                 = cur_q;
    assign bus.m_axis_tdata_owner_programID = slot_q[cur_q].owner;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StIssue;
            StIssue: if (bus.m_axis_tready) state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Accepted slot was free pre-edge and a hit slot was issued pre-edge, so the completion,
    // handshake and accept updates never target the same slot in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q            <= '0;
            dispatched_count <= '0;
            stall_cycles     <= '0;
            spurious_done    <= '0;
            for (int i = 0; i < NUM_EXECUTORS; i++) begin
                slot_q[i] <= '0;
                rd_q[i]   <= '0;
                wr_q[i]   <= '0;
            end
        end else begin
            if (bus.done_valid) begin
                if (done_hit) begin
                    slot_q[bus.done_slot].busy   <= 1'b0;
                    slot_q[bus.done_slot].issued <= 1'b0;
                end else begin
                    spurious_done <= spurious_done + 32'd1;
                end
            end
            if (handshake) begin
                slot_q[cur_q].issued <= 1'b1;
                dispatched_count     <= dispatched_count + 32'd1;
            end
            if (accept) begin
                cur_q            <= free_idx;
                slot_q[free_idx] <= '{busy: 1'b1, issued: 1'b0,
                                      owner: bus.s_axis_tdata_owner_programID};
                rd_q[free_idx]   <= bus.s_axis_tdata_read_dependencies;
                wr_q[free_idx]   <= bus.s_axis_tdata_write_dependencies;
            end
            if (bus.s_axis_tvalid && !ready) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_dispatch.sv
// Self-checking bench for dispatch: directed scenarios plus randomized traffic against a
// slot-level reference model.
module tb_dispatch;
    import dispatch_pkg::*;

    localparam int unsigned MD = 256;
    localparam int unsigned NE = 4;
    localparam int unsigned SW = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] inflight_count, dispatched_count, stall_cycles, spurious_done;

    dispatch_if #(.MAX_DEPENDENCIES(MD), .SLOT_W(SW)) bus ();

    dispatch #(
        .MAX_DEPENDENCIES(MD),
        .NUM_EXECUTORS   (NE),
        .SLOT_W          (SW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus),
        .inflight_count  (inflight_count),
        .dispatched_count(dispatched_count),
        .stall_cycles    (stall_cycles),
        .spurious_done   (spurious_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: what each executor slot holds and whether an issue is outstanding.
    bit          mb [NE];
    bit          mi [NE];
    logic [63:0] mo [NE];
    logic [MD-1:0] mr [NE];
    logic [MD-1:0] mw [NE];
    bit          mpend;
    int          mslot;
    logic [31:0] e_disp, e_stall, e_spur;

    function automatic bit conflicts(input logic [MD-1:0] r, input logic [MD-1:0] w);
        for (int k = 0; k < NE; k++) begin
            if (mb[k] && ((((r | w) & mw[k]) != '0) || ((w & mr[k]) != '0))) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic int lowest_free();
        for (int k = 0; k < NE; k++) if (!mb[k]) return k;
        return -1;
    endfunction

    function automatic bit exp_ready();
        if (mpend || lowest_free() < 0) return 1'b0;
        return !conflicts(bus.s_axis_tdata_read_dependencies, bus.s_axis_tdata_write_dependencies);
    endfunction

    function automatic int busy_count();
        int n = 0;
        for (int k = 0; k < NE; k++) n += int'(mb[k]);
        return n;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NE; k++) begin
            mb[k] = 0; mi[k] = 0; mo[k] = '0; mr[k] = '0; mw[k] = '0;
        end
        mpend = 0; mslot = 0; e_disp = 0; e_stall = 0; e_spur = 0;
    endtask

    task automatic model_edge();
        bit rdy = exp_ready();
        int fs  = lowest_free();
        int ds  = int'(bus.done_slot);
        bit acc = bus.s_axis_tvalid && rdy;
        if (bus.s_axis_tvalid && !rdy) e_stall++;
        if (bus.done_valid) begin
            if (mb[ds] && mi[ds]) begin
                mb[ds] = 0; mi[ds] = 0;
            end else begin
                e_spur++;
            end
        end
        if (mpend && bus.m_axis_tready) begin
            mi[mslot] = 1; e_disp++; mpend = 0;
        end
        if (acc) begin
            mb[fs] = 1; mi[fs] = 0;
            mo[fs] = bus.s_axis_tdata_owner_programID;
            mr[fs] = bus.s_axis_tdata_read_dependencies;
            mw[fs] = bus.s_axis_tdata_write_dependencies;
            mslot = fs; mpend = 1;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [63:0] owner, input logic [MD-1:0] r, input logic [MD-1:0] w);
        bus.s_axis_tvalid                   = 1'b1;
        bus.s_axis_tdata_owner_programID    = owner;
        bus.s_axis_tdata_read_dependencies  = r;
        bus.s_axis_tdata_write_dependencies = w;
    endtask

    task automatic done(input bit v, input int slot);
        bus.done_valid = v;
        bus.done_slot  = SW'(slot);
    endtask

    function automatic logic [MD-1:0] bitv(input int b);
        logic [MD-1:0] v = '0;
        v[b] = 1'b1;
        return v;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        send(64'hAB, '0, bitv(1));
        #1;
        n_checks++; if (bus.s_axis_tready !== 1'b0) begin n_fail++;
            $display("FAIL reset_tready got=%0b exp=0", bus.s_axis_tready); end
        n_checks++; if (bus.m_axis_tvalid !== 1'b0 || bus.m_axis_tdest !== '0) begin n_fail++;
            $display("FAIL reset_issue got=%0b/%0d exp=0/0", bus.m_axis_tvalid, bus.m_axis_tdest); end
        n_checks++; if (bus.m_axis_tdata_owner_programID !== 64'h0) begin n_fail++;
            $display("FAIL reset_owner got=%0h exp=0", bus.m_axis_tdata_owner_programID); end
        n_checks++;
        if ({inflight_count, dispatched_count, stall_cycles, spurious_done} !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_counters got=%0d/%0d/%0d/%0d exp=0", inflight_count,
                     dispatched_count, stall_cycles, spurious_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        #1;
        n_checks++; if (bus.s_axis_tready !== 1'b1) begin n_fail++;
            $display("FAIL release_tready got=%0b exp=1", bus.s_axis_tready); end
        bus.s_axis_tvalid = 1'b0;
    endtask

    task automatic test_basic();
        bus.m_axis_tready = 1'b1;
        send(64'h11, '0, bitv(3));
        #1;
        n_checks++; if (bus.s_axis_tready !== 1'b1) begin n_fail++;
            $display("FAIL basic_tready got=%0b exp=1", bus.s_axis_tready); end
        tick();
        bus.s_axis_tvalid = 1'b0;
        #1;
        n_checks++;
        if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdest !== 2'd0
            || bus.m_axis_tdata_owner_programID !== 64'h11) begin
            n_fail++;
            $display("FAIL basic_issue got=%0b/%0d/%0h exp=1/0/11", bus.m_axis_tvalid,
                     bus.m_axis_tdest, bus.m_axis_tdata_owner_programID);
        end
        tick();
        #1;
        n_checks++; if (dispatched_count !== 32'd1 || inflight_count !== 32'd1) begin n_fail++;
            $display("FAIL basic_counts got=%0d/%0d exp=1/1", dispatched_count, inflight_count); end
        n_checks++; if (bus.m_axis_tvalid !== 1'b0) begin n_fail++;
            $display("FAIL basic_idle got=%0b exp=0", bus.m_axis_tvalid); end
    endtask

    // Slot 0 still holds w={3}; a reader of bit 3 must wait for its completion.
    task automatic test_hazard();
        logic [31:0] st0 = stall_cycles;
        send(64'h22, bitv(3), '0);
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++; if (bus.s_axis_tready !== 1'b0) begin n_fail++;
                $display("FAIL raw_tready got=%0b exp=0", bus.s_axis_tready); end
            tick();
        end
        n_checks++; if (stall_cycles !== st0 + 32'd3 || stall_cycles !== e_stall) begin n_fail++;
            $display("FAIL raw_stalls got=%0d exp=%0d", stall_cycles, st0 + 32'd3); end
        done(1, 0);
        #1;
        n_checks++; if (bus.s_axis_tready !== 1'b0) begin n_fail++;
            $display("FAIL raw_same_cycle got=%0b exp=0", bus.s_axis_tready); end
        tick();
        done(0, 0);
        #1;
        n_checks++; if (bus.s_axis_tready !== 1'b1) begin n_fail++;
            $display("FAIL raw_release got=%0b exp=1", bus.s_axis_tready); end
        tick();
        bus.s_axis_tvalid = 1'b0;
        #1;
        n_checks++; if (bus.m_axis_tdest !== 2'd0 || bus.m_axis_tdata_owner_programID !== 64'h22)
        begin n_fail++;
            $display("FAIL raw_issue got=%0d/%0h exp=0/22", bus.m_axis_tdest,
                     bus.m_axis_tdata_owner_programID); end
        tick();
        done(1, 0);
        tick();
        done(0, 0);
    endtask

    task automatic test_fill();
        bus.m_axis_tready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            send(64'h100 + 64'(k), '0, bitv(10 + k));
            tick();
            bus.s_axis_tvalid = 1'b0;
            #1;
            n_checks++; if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdest !== SW'(k)) begin
                n_fail++;
                $display("FAIL fill_tdest got=%0b/%0d exp=1/%0d", bus.m_axis_tvalid,
                         bus.m_axis_tdest, k); end
            tick();
        end
        send(64'h200, '0, bitv(20));
        #1;
        n_checks++; if (bus.s_axis_tready !== 1'b0 || inflight_count !== 32'd4) begin n_fail++;
            $display("FAIL full_stall got=%0b/%0d exp=0/4", bus.s_axis_tready, inflight_count); end
        tick();
        done(1, 2);
        tick();
        done(0, 0);
        tick();
        bus.s_axis_tvalid = 1'b0;
        #1;
        n_checks++;
        if (bus.m_axis_tdest !== 2'd2 || bus.m_axis_tdata_owner_programID !== 64'h200) begin
            n_fail++;
            $display("FAIL fill_reuse got=%0d/%0h exp=2/200", bus.m_axis_tdest,
                     bus.m_axis_tdata_owner_programID); end
        tick();
        for (int k = 0; k < 4; k++) begin
            done(1, k);
            tick();
        end
        done(0, 0);
    endtask

    task automatic test_backpressure();
        logic [31:0] d0 = dispatched_count;
        bus.m_axis_tready = 1'b0;
        send(64'h333, '0, bitv(40));
        tick();
        send(64'h444, '0, bitv(41));
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++;
            if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdest !== 2'd0
                || bus.m_axis_tdata_owner_programID !== 64'h333 || bus.s_axis_tready !== 1'b0)
            begin
                n_fail++;
                $display("FAIL hold got=%0b/%0d/%0h/%0b exp=1/0/333/0", bus.m_axis_tvalid,
                         bus.m_axis_tdest, bus.m_axis_tdata_owner_programID, bus.s_axis_tready);
            end
            tick();
        end
        bus.s_axis_tvalid = 1'b0;
        bus.m_axis_tready = 1'b1;
        tick();
        tick();
        #1;
        n_checks++; if (dispatched_count !== d0 + 32'd1 || bus.m_axis_tvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_release got=%0d/%0b exp=%0d/0", dispatched_count,
                     bus.m_axis_tvalid, d0 + 32'd1); end
        done(1, 0);
        tick();
        done(0, 0);
    endtask

    task automatic test_spurious();
        logic [31:0] sp0 = spurious_done;
        done(1, 1);
        tick();
        done(0, 0);
        bus.m_axis_tready = 1'b0;
        send(64'h555, '0, bitv(50));
        tick();
        bus.s_axis_tvalid = 1'b0;
        done(1, 0);
        tick();
        done(0, 0);
        #1;
        n_checks++; if (spurious_done !== sp0 + 32'd2 || spurious_done !== e_spur) begin n_fail++;
            $display("FAIL spurious got=%0d exp=%0d", spurious_done, sp0 + 32'd2); end
        n_checks++; if (inflight_count !== 32'd1 || bus.m_axis_tvalid !== 1'b1) begin n_fail++;
            $display("FAIL spurious_busy got=%0d/%0b exp=1/1", inflight_count,
                     bus.m_axis_tvalid); end
        bus.m_axis_tready = 1'b1;
        tick();
    endtask

    // Slot 0 is busy from the previous test, so the pending issue sits on slot 1.
    task automatic test_reset_mid_issue();
        bus.m_axis_tready = 1'b0;
        send(64'h666, '0, bitv(70));
        tick();
        bus.s_axis_tvalid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.m_axis_tvalid !== 1'b0 || inflight_count !== 32'd0) begin n_fail++;
            $display("FAIL rst_mid got=%0b/%0d exp=0/0", bus.m_axis_tvalid, inflight_count); end
        n_checks++; if ({dispatched_count, stall_cycles, spurious_done} !== 96'h0) begin
            n_fail++;
            $display("FAIL rst_mid_counters got=%0d/%0d/%0d exp=0", dispatched_count,
                     stall_cycles, spurious_done); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        bus.m_axis_tready = 1'b1;
        send(64'h777, '0, bitv(60));
        tick();
        bus.s_axis_tvalid = 1'b0;
        #1;
        n_checks++; if (bus.m_axis_tdest !== 2'd0 || bus.m_axis_tvalid !== 1'b1) begin n_fail++;
            $display("FAIL rst_reuse got=%0d/%0b exp=0/1", bus.m_axis_tdest, bus.m_axis_tvalid); end
        tick();
        done(1, 1);
        tick();
        done(0, 0);
        #1;
        n_checks++; if (spurious_done !== 32'd1) begin n_fail++;
            $display("FAIL rst_forgotten got=%0d exp=1", spurious_done); end
    endtask

    task automatic test_random();
        logic [MD-1:0] r, w;
        for (int c = 0; c < 600; c++) begin
            r = '0;
            w = '0;
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 5) == 0) r[b] = 1'b1;
                if ($urandom_range(0, 7) == 0) w[b] = 1'b1;
            end
            send({$urandom, $urandom}, r, w);
            bus.s_axis_tvalid = ($urandom_range(0, 2) != 0);
            bus.m_axis_tready = ($urandom_range(0, 3) != 0);
            done($urandom_range(0, 2) == 0, int'($urandom_range(0, NE - 1)));
            #1;
            n_checks++; if (bus.s_axis_tready !== exp_ready()) begin n_fail++;
                $display("FAIL rnd_tready c=%0d got=%0b exp=%0b", c, bus.s_axis_tready,
                         exp_ready()); end
            n_checks++; if (bus.m_axis_tvalid !== mpend) begin n_fail++;
                $display("FAIL rnd_tvalid c=%0d got=%0b exp=%0b", c, bus.m_axis_tvalid, mpend); end
            if (mpend) begin
                n_checks++;
                if (bus.m_axis_tdest !== SW'(mslot)
                    || bus.m_axis_tdata_owner_programID !== mo[mslot]) begin
                    n_fail++;
                    $display("FAIL rnd_issue c=%0d got=%0d/%0h exp=%0d/%0h", c, bus.m_axis_tdest,
                             bus.m_axis_tdata_owner_programID, mslot, mo[mslot]);
                end
            end
            n_checks++; if (inflight_count !== 32'(busy_count())) begin n_fail++;
                $display("FAIL rnd_inflight c=%0d got=%0d exp=%0d", c, inflight_count,
                         busy_count()); end
            n_checks++;
            if (dispatched_count !== e_disp || stall_cycles !== e_stall
                || spurious_done !== e_spur) begin
                n_fail++;
                $display("FAIL rnd_counters c=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", c,
                         dispatched_count, stall_cycles, spurious_done, e_disp, e_stall, e_spur);
            end
            tick();
        end
        bus.s_axis_tvalid = 1'b0;
        done(0, 0);
    endtask

    initial begin
        bus.s_axis_tvalid                   = 1'b0;
        bus.s_axis_tdata_owner_programID    = '0;
        bus.s_axis_tdata_read_dependencies  = '0;
        bus.s_axis_tdata_write_dependencies = '0;
        bus.m_axis_tready                   = 1'b0;
        bus.done_valid                      = 1'b0;
        bus.done_slot                       = '0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_basic();
        test_hazard();
        test_fill();
        test_backpressure();
        test_spurious();
        test_reset_mid_issue();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
